uart_tx: RTL

Serial byte transmitter for the capture-dump path. Consumes bytes from the RAM read-out stage over a valid/ack handshake and serialises each one onto `txd` as a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, and 1 or 2 stop bits. It sits between the RAM transmit sequencer and the board's UART TX pin, and is the only block that drives `txd`.

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte hand-off between the RAM read-out stage (master) and uart_tx (slave).
// The producer holds tx_data_valid as a level; the transmitter answers with a one-cycle tx_data_ack.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ack;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_data_ack
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_data_ack
  );
endinterface

// File: rtl/uart_tx.sv
// Async serial byte transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Ack and txd/busy appear the cycle after acceptance; bytes are only taken in IDLE or on the last stop-bit edge.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_if.slave    bus,
  output logic        txd,
  output logic        tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             parity_q, parity_d;
  logic             stop_idx_q, stop_idx_d;
  logic             txd_q, txd_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  logic bit_end;
  logic last_stop;
  logic accept;

  assign bit_end   = (baud_cnt_q == CNT_MAX);
  assign last_stop = (STOP_BITS < 2) ? 1'b1 : stop_idx_q;

  // The final stop-bit edge doubles as an acceptance point so back-to-back frames have no idle gap.
  assign accept = bus.tx_data_valid &&
                  ((state_q == S_IDLE) ||
                   ((state_q == S_STOP) && bit_end && last_stop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.tx_data_valid) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx_q == 3'd7)) state_d = PARITY_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end && last_stop) state_d = bus.tx_data_valid ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_d = (state_q == S_IDLE || bit_end) ? '0 : baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;
    ack_d      = accept;
    busy_d     = (state_d != S_IDLE);

    if (accept) begin
      shreg_d    = bus.tx_data;
      parity_d   = (^bus.tx_data) ^ PARITY_ODD;
      txd_d      = 1'b0;
      bit_idx_d  = 3'd0;
      stop_idx_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: txd_d = 1'b1;
        S_START: begin
          if (bit_end) begin
            txd_d   = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              txd_d      = PARITY_EN ? parity_q : 1'b1;
              bit_idx_d  = 3'd0;
              stop_idx_d = 1'b0;
            end else begin
              txd_d     = shreg_q[0];
              shreg_d   = {1'b0, shreg_q[7:1]};
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            txd_d      = 1'b1;
            stop_idx_d = 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            txd_d = 1'b1;
            if (!last_stop) stop_idx_d = 1'b1;
          end
        end
        default: txd_d = 1'b1;
      endcase
    end
  end

  assign txd             = txd_q;
  assign tx_busy         = busy_q;
  assign bus.tx_data_ack = ack_q;

endmodule
